// File: rtl/ledsuit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ledsuit_pkg                                                  |
// | Description : WS2812 timing defaults, streamer state encoding, gamma curve |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package ledsuit_pkg;

  localparam int C_T_BIT   = 70;
  localparam int C_T0H     = 20;
  localparam int C_T1H     = 50;
  localparam int C_T_LATCH = 50000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_LATCH    = 2'd3
  } strm_state_t;

  // Gamma-2.2 curve approximated as 255*(0.75*t^2 + 0.25*t^3), t = x/255.
  function automatic logic [7:0] gamma22(input logic [7:0] x);
    logic [25:0] w_x;
    logic [25:0] w_num;
    w_x   = {18'd0, x};
    w_num = w_x * w_x * (26'd765 + w_x);
    return 8'(w_num / 26'd260100);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ws2812_bit_encoder                                           |
// | Description : One WS2812 NRZ bit per handshake, back-to-back, registered do|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ws2812_bit_encoder #(
  parameter int T_BIT = 70,
  parameter int T0H   = 20,
  parameter int T1H   = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic i_bit_valid,
  input  logic i_bit_in,
  output logic o_bit_ready,
  output logic o_do
);

  localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;

  logic          r_active;
  logic [CW-1:0] r_cnt;
  logic          r_bit;
  logic          r_do;
  logic          w_last;
  logic          w_take;
  logic          w_fall;

  // Ready on the final slot of a bit so the next bit starts with no gap.
  assign w_last      = r_active && (r_cnt == CW'(T_BIT - 1));
  assign o_bit_ready = !r_active || w_last;
  assign w_take      = i_bit_valid && o_bit_ready;
  assign w_fall      = (r_cnt == (r_bit ? CW'(T1H - 1) : CW'(T0H - 1)));
  assign o_do        = r_do;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= 1'b0;
      r_do     <= 1'b0;
    end else if (w_take) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_bit    <= i_bit_in;
      r_do     <= 1'b1;
    end else if (w_last) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_do     <= 1'b0;
    end else if (r_active) begin
      r_cnt <= r_cnt + CW'(1);
      if (w_fall) r_do <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ws2812_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ws2812_frame_streamer                                        |
// | Description : Streams G,R,B pixels from BRAM port A as WS2812 frames with  |
// |               a latch gap; WS2812_GAMMA_EN adds a gamma stage on capture.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ws2812_frame_streamer
  import ledsuit_pkg::*;
#(
  parameter int NUM_LEDS  = 160,
  parameter int ADDR_W    = 13,
  parameter int BASE_ADDR = 0,
  parameter int T_BIT     = C_T_BIT,
  parameter int T0H       = C_T0H,
  parameter int T1H       = C_T1H,
  parameter int T_LATCH   = C_T_LATCH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_dout,
  output logic              led_strip_do,
  output logic              busy,
  output logic              frame_done
);

  localparam int PW = $clog2(NUM_LEDS + 1);
  localparam int LW = (T_LATCH > 1) ? $clog2(T_LATCH) : 1;

  strm_state_t       r_state;
  strm_state_t       w_state_nxt;
  logic [1:0]        r_iss_left;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_vld;
  logic [1:0]        r_rd_lane;
  logic [23:0]       r_shadow;
  logic [23:0]       r_shift;
  logic [4:0]        r_bit;
  logic [PW-1:0]     r_pix;
  logic              r_all_sent;
  logic [LW-1:0]     r_lcnt;

  logic              w_issue;
  logic [1:0]        w_iss_lane;
  logic              w_cap_vld;
  logic [1:0]        w_cap_lane;
  logic [7:0]        w_cap_byte;
  logic              w_enc_valid;
  logic              w_enc_ready;
  logic              w_take;
  logic              w_pf_done;
  logic              w_shift_done;
  logic              w_latch_end;
  logic              w_frame_start;
  logic              w_fetch_next;

  assign w_issue      = (r_iss_left != 2'd0);
  assign w_iss_lane   = 2'd3 - r_iss_left;
  assign mem_en       = w_issue;
  assign mem_addr     = r_addr;

  assign w_enc_valid  = (r_state == ST_SHIFT) && !r_all_sent;
  assign w_take       = w_enc_valid && w_enc_ready;
  assign w_pf_done    = (r_state == ST_PREFETCH) && w_cap_vld && (w_cap_lane == 2'd2);
  assign w_shift_done = (r_state == ST_SHIFT) && r_all_sent && w_enc_ready;
  assign w_latch_end  = (r_state == ST_LATCH) && (r_lcnt == LW'(T_LATCH - 1));
  // Next pixel is fetched while bit 0 of the current one is on the wire.
  assign w_fetch_next = w_take && (r_bit == 5'd0) && (r_pix != PW'(NUM_LEDS - 1));

`ifdef WS2812_GAMMA_EN
  logic       r_g_vld;
  logic [1:0] r_g_lane;
  logic [7:0] r_g_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_g_vld  <= 1'b0;
      r_g_lane <= 2'd0;
      r_g_byte <= 8'd0;
    end else begin
      r_g_vld  <= r_rd_vld;
      r_g_lane <= r_rd_lane;
      r_g_byte <= gamma22(mem_dout);
    end
  end

  assign w_cap_vld  = r_g_vld;
  assign w_cap_lane = r_g_lane;
  assign w_cap_byte = r_g_byte;
`else
  assign w_cap_vld  = r_rd_vld;
  assign w_cap_lane = r_rd_lane;
  assign w_cap_byte = mem_dout;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    busy          = (r_state != ST_IDLE);
    frame_done    = w_latch_end;
    case (r_state)
      ST_IDLE:     if (run)          w_state_nxt = ST_PREFETCH;
      ST_PREFETCH: if (w_pf_done)    w_state_nxt = ST_SHIFT;
      ST_SHIFT:    if (w_shift_done) w_state_nxt = ST_LATCH;
      ST_LATCH:    if (w_latch_end)  w_state_nxt = run ? ST_PREFETCH : ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
    w_frame_start = (w_state_nxt == ST_PREFETCH) && (r_state != ST_PREFETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_left <= 2'd0;
      r_addr     <= ADDR_W'(BASE_ADDR);
      r_rd_vld   <= 1'b0;
      r_rd_lane  <= 2'd0;
      r_shadow   <= '0;
      r_shift    <= '0;
      r_bit      <= 5'd0;
      r_pix      <= '0;
      r_all_sent <= 1'b0;
      r_lcnt     <= '0;
    end else begin
      r_rd_vld  <= w_issue;
      r_rd_lane <= w_iss_lane;

      // The address stays on the pixel's last byte between bursts.
      if (w_frame_start) begin
        r_iss_left <= 2'd3;
        r_addr     <= ADDR_W'(BASE_ADDR);
      end else if (w_fetch_next) begin
        r_iss_left <= 2'd3;
        r_addr     <= r_addr + ADDR_W'(1);
      end else if (w_issue) begin
        r_iss_left <= r_iss_left - 2'd1;
        if (r_iss_left != 2'd1) r_addr <= r_addr + ADDR_W'(1);
      end

      if (w_cap_vld) begin
        case (w_cap_lane)
          2'd0:    r_shadow[23:16] <= w_cap_byte;
          2'd1:    r_shadow[15:8]  <= w_cap_byte;
          default: r_shadow[7:0]   <= w_cap_byte;
        endcase
      end

      if (w_pf_done) begin
        r_shift    <= {r_shadow[23:8], w_cap_byte};
        r_bit      <= 5'd0;
        r_pix      <= '0;
        r_all_sent <= 1'b0;
      end else if (w_take) begin
        if (r_bit == 5'd23) begin
          r_bit   <= 5'd0;
          r_shift <= r_shadow;
          if (r_pix == PW'(NUM_LEDS - 1)) r_all_sent <= 1'b1;
          else                            r_pix      <= r_pix + PW'(1);
        end else begin
          r_bit   <= r_bit + 5'd1;
          r_shift <= {r_shift[22:0], 1'b0};
        end
      end

      if (r_state != ST_LATCH)  r_lcnt <= '0;
      else if (!w_latch_end)    r_lcnt <= r_lcnt + LW'(1);
    end
  end

  ws2812_bit_encoder #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_enc (
    .clk         (clk),
    .rst         (rst),
    .i_bit_valid (w_enc_valid),
    .i_bit_in    (r_shift[23]),
    .o_bit_ready (w_enc_ready),
    .o_do        (led_strip_do)
  );

endmodule
`default_nettype wire
